// File: rtl/mine_pkg.sv
`timescale 1ns/1ps
// mine_pkg: board geometry, FSM state encoding and LFSR constants shared by the
// mine placer and its LFSR.
package mine_pkg;

    localparam int BOARD_CELLS = 9;
    localparam int CELL_IDX_W  = 4;
    localparam int LFSR_W      = 8;

    // Feedback taps 7,5,4,3 give the maximal-length polynomial x^8+x^6+x^5+x^4+1.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mine_lfsr.sv
`timescale 1ns/1ps
// mine_lfsr: free-running 8-bit Fibonacci LFSR, loaded with i_seed on reset.
// The seed must be non-zero; the parent guarantees this.
module mine_lfsr
    import mine_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= i_seed;
        end else begin
            r_state <= lfsrNext(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/mine_placer.sv
`timescale 1ns/1ps
// mine_placer: places a clamped number of mines on a 3x3 board from LFSR candidates.
// Define MINE_PLACER_SAFE_CELL_EN to add in_safe_cell, a cell that never gets a mine.
module mine_placer
    import mine_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5,
    parameter int                MAX_MINES = 8
) (
    input  logic                   in_clka,
    input  logic                   in_restart,
    input  logic                   in_place,
    input  logic [CELL_IDX_W-1:0]  in_mine_count,
`ifdef MINE_PLACER_SAFE_CELL_EN
    input  logic [CELL_IDX_W-1:0]  in_safe_cell,
`endif
    output logic [BOARD_CELLS-1:0] out_mines,
    output logic                   out_place_done,
    output logic                   out_busy,
    output logic [1:0]             out_state
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0]     SEED_EFF  = (LFSR_SEED == '0) ? 8'h01 : LFSR_SEED;
    localparam logic [CELL_IDX_W-1:0] MAX_CLAMP = CELL_IDX_W'(MAX_MINES);
    localparam logic [CELL_IDX_W-1:0] NUM_CELLS = CELL_IDX_W'(BOARD_CELLS);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [BOARD_CELLS-1:0] r_mines;
    logic [CELL_IDX_W-1:0]  r_remaining;
    logic [LFSR_W-1:0]      w_lfsr;
    logic [CELL_IDX_W-1:0]  w_candidate;
    logic [BOARD_CELLS-1:0] w_candMask;
    logic [CELL_IDX_W-1:0]  w_clampedCount;
    logic                   w_candFree;
    logic                   w_candSafe;
    logic                   w_accept;
    logic                   w_unusedLfsr;

    mine_lfsr u_lfsr (
        .i_clock (in_clka),
        .i_reset (in_restart),
        .i_seed  (SEED_EFF),
        .o_state (w_lfsr)
    );

    assign w_candidate  = w_lfsr[CELL_IDX_W-1:0];
    assign w_unusedLfsr = ^w_lfsr[LFSR_W-1:CELL_IDX_W];
    assign w_candMask   = BOARD_CELLS'(1) << w_candidate;
    assign w_candFree   = (w_candidate < NUM_CELLS) && ((r_mines & w_candMask) == '0);

`ifdef MINE_PLACER_SAFE_CELL_EN
    logic [CELL_IDX_W-1:0] r_safeCell;

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_safeCell <= '1;
        end else if (r_state == ST_IDLE && in_place) begin
            r_safeCell <= in_safe_cell;
        end
    end

    assign w_candSafe = (r_safeCell >= NUM_CELLS) || (w_candidate != r_safeCell);
`else
    assign w_candSafe = 1'b1;
`endif

    // Once the count is exhausted the map is frozen while the FSM moves to DONE.
    assign w_accept = (r_state == ST_PLACE) && (r_remaining != '0) && w_candFree && w_candSafe;

    always_comb begin
        w_clampedCount = in_mine_count;
        if (in_mine_count == '0) begin
            w_clampedCount = CELL_IDX_W'(1);
        end else if (in_mine_count > MAX_CLAMP) begin
            w_clampedCount = MAX_CLAMP;
        end
    end

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (in_place) w_nextState = ST_PLACE;
            ST_PLACE: if (r_remaining == '0) w_nextState = ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_mines     <= '0;
            r_remaining <= '0;
        end else if (r_state == ST_IDLE && in_place) begin
            r_mines     <= '0;
            r_remaining <= w_clampedCount;
        end else if (w_accept) begin
            r_mines     <= r_mines | w_candMask;
            r_remaining <= r_remaining - CELL_IDX_W'(1);
        end
    end

    always_comb begin
        out_place_done = (r_state == ST_DONE);
        out_busy       = (r_state == ST_PLACE) || (r_state == ST_DONE);
        out_state      = r_state;
        out_mines      = r_mines;
    end

endmodule

// File: tb/tb_mine_placer.sv
`timescale 1ns/1ps
// tb_mine_placer: directed self-checking bench for mine_placer with a small
// behavioural model of the LFSR and placement walk.
module tb_mine_placer;

    logic       in_clka = 1'b0;
    logic       in_restart = 1'b0;
    logic       in_place = 1'b0;
    logic [3:0] in_mine_count = 4'd0;
`ifdef MINE_PLACER_SAFE_CELL_EN
    logic [3:0] in_safe_cell = 4'hF;
`endif
    logic [8:0] out_mines;
    logic       out_place_done;
    logic       out_busy;
    logic [1:0] out_state;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    logic [7:0] mLfsr;
    logic [7:0] startL;

    mine_placer #(.LFSR_SEED(8'hA5), .MAX_MINES(8)) dut (
        .in_clka        (in_clka),
        .in_restart     (in_restart),
        .in_place       (in_place),
        .in_mine_count  (in_mine_count),
`ifdef MINE_PLACER_SAFE_CELL_EN
        .in_safe_cell   (in_safe_cell),
`endif
        .out_mines      (out_mines),
        .out_place_done (out_place_done),
        .out_busy       (out_busy),
        .out_state      (out_state)
    );

    always #5 in_clka = ~in_clka;

    // Reference LFSR tracking the DUT's sequence from the same reset.
    function automatic logic [7:0] modelNext(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    always @(posedge in_clka) begin
        if (in_restart) mLfsr <= 8'hA5;
        else            mLfsr <= modelNext(mLfsr);
    end

    always @(posedge in_clka) begin
        if (out_place_done) doneCount <= doneCount + 1;
    end

    function automatic int clampCount(input int req);
        if (req == 0) return 1;
        if (req > 8)  return 8;
        return req;
    endfunction

    // Walks the LFSR from the value seen in the first PLACE cycle.
    function automatic logic [8:0] placeModel(input logic [7:0] l0, input int req, input int safe);
        logic [8:0] m;
        logic [7:0] l;
        logic [3:0] c;
        int cnt;
        m = '0;
        l = l0;
        cnt = clampCount(req);
        for (int i = 0; i < 600 && cnt > 0; i++) begin
            c = l[3:0];
            if (c < 4'd9 && (m & (9'b1 << c)) == '0 && (safe > 8 || int'(c) != safe)) begin
                m = m | (9'b1 << c);
                cnt--;
            end
            l = modelNext(l);
        end
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        @(negedge in_clka);
        in_restart = 1'b1;
        in_place = 1'b0;
        repeat (2) @(negedge in_clka);
        in_restart = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the first PLACE cycle.
    task automatic applyStimulus(input logic [3:0] count);
        in_place = 1'b1;
        in_mine_count = count;
        @(negedge in_clka);
        in_place = 1'b0;
        startL = mLfsr;
        checkOutput("enter_place", 16'(out_state), 16'd1);
    endtask

    task automatic waitDone(input string tag, input logic [8:0] expMap, input int expPop);
        int n;
        n = 0;
        while (!out_place_done && n < 300) begin
            @(negedge in_clka);
            n++;
        end
        checkOutput({tag, "_done"}, 16'(out_place_done), 16'd1);
        checkOutput({tag, "_map"}, 16'(out_mines), 16'(expMap));
        checkOutput({tag, "_pop"}, 16'($countones(out_mines)), 16'(expPop));
        @(negedge in_clka);
        checkOutput({tag, "_pulse_end"}, 16'(out_place_done), 16'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [8:0] expMap;
        logic       stable;
        int         snap;

        // Reset state
        doReset();
        checkOutput("rst_mines", 16'(out_mines), 16'h000);
        checkOutput("rst_done", 16'(out_place_done), 16'd0);
        checkOutput("rst_busy", 16'(out_busy), 16'd0);
        checkOutput("rst_state", 16'(out_state), 16'd0);

        // Nominal three-mine placement, then map must hold through idle
        repeat (3) @(negedge in_clka);
        snap = doneCount;
        applyStimulus(4'd3);
        checkOutput("nom_busy", 16'(out_busy), 16'd1);
        expMap = placeModel(startL, 3, 15);
        waitDone("nominal", expMap, 3);
        stable = 1'b1;
        repeat (20) begin
            @(negedge in_clka);
            if (out_mines !== expMap || out_state !== 2'd0) stable = 1'b0;
        end
        checkOutput("nom_stable", 16'(stable), 16'd1);
        checkOutput("nom_pulses", 16'(doneCount - snap), 16'd1);

        // Count clamping at both ends
        applyStimulus(4'd0);
        waitDone("clamp0", placeModel(startL, 0, 15), 1);
        applyStimulus(4'd12);
        waitDone("clamp12", placeModel(startL, 12, 15), 8);
        applyStimulus(4'd9);
        waitDone("clamp9", placeModel(startL, 9, 15), 8);

        // in_place re-asserted mid-placement is ignored
        snap = doneCount;
        applyStimulus(4'd8);
        in_place = 1'b1;
        @(negedge in_clka);
        in_place = 1'b0;
        checkOutput("intf_still_place", 16'(out_state), 16'd1);
        waitDone("interfere", placeModel(startL, 8, 15), 8);
        repeat (30) @(negedge in_clka);
        checkOutput("intf_pulses", 16'(doneCount - snap), 16'd1);

        // Restart at PLACE cycle 5 aborts without a done pulse
        applyStimulus(4'd8);
        repeat (4) @(negedge in_clka);
        checkOutput("abort_pre_state", 16'(out_state), 16'd1);
        snap = doneCount;
        in_restart = 1'b1;
        in_place = 1'b1;
        @(negedge in_clka);
        in_restart = 1'b0;
        in_place = 1'b0;
        checkOutput("abort_mines", 16'(out_mines), 16'h000);
        checkOutput("abort_state", 16'(out_state), 16'd0);
        checkOutput("abort_busy", 16'(out_busy), 16'd0);
        repeat (40) @(negedge in_clka);
        checkOutput("abort_no_pulse", 16'(doneCount - snap), 16'd0);

        // in_place held across DONE->IDLE restarts in the first IDLE cycle
        in_place = 1'b1;
        in_mine_count = 4'd2;
        @(negedge in_clka);
        startL = mLfsr;
        waitDone("held1", placeModel(startL, 2, 15), 2);
        checkOutput("held_idle", 16'(out_state), 16'd0);
        @(negedge in_clka);
        in_place = 1'b0;
        startL = mLfsr;
        checkOutput("held_restart", 16'(out_state), 16'd1);
        waitDone("held2", placeModel(startL, 2, 15), 2);

        // Determinism: same reset-to-request distance gives the same map
        for (int run = 0; run < 2; run++) begin
            doReset();
            repeat (9) @(negedge in_clka);
            applyStimulus(4'd3);
            waitDone($sformatf("determ%0d", run), placeModel(startL, 3, 15), 3);
        end

`ifdef MINE_PLACER_SAFE_CELL_EN
        in_safe_cell = 4'd4;
        applyStimulus(4'd8);
        waitDone("safe4", 9'h1EF, 8);
        in_safe_cell = 4'd12;
        applyStimulus(4'd5);
        waitDone("safe_none", placeModel(startL, 5, 12), 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
